pipe_stall_ctrl: RTL
====================

Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Generates the load and flush enables for the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB pipe registers from I-/D-memory handshakes, load-use hazards and branch redirects resolved in MEM.
- Holds a pending redirect target while a wrong-path instruction fetch is still outstanding, then applies it.
- Keeps saturating performance counters for stall cycles and redirects.

Parameters:
- CNT_W, 16, width of the stall_cycles and redirect_count counters.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low (0 = reset).
- imem_read  input  1  IF fetch request active.
- imem_resp  input  1  I-memory response, one-cycle pulse.
- dmem_read  input  1  MEM-stage load request.
- dmem_write  input  1  MEM-stage store request.
- dmem_resp  input  1  D-memory response, one-cycle pulse.
- load_use_hazard  input  1  ID instruction depends on a load in EX.
- MEM_pc_mux_sel  input  1  taken branch/jump resolved in MEM.
- MEM_jmp_pc  input  32  redirect target from MEM.
- load_pc  output  1  PC register enable.
- pc_sel  output  1  1 = PC takes pc_target, 0 = sequential PC.
- pc_target  output  32  redirect target.
- load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB  output  1 each  pipe register enables.
- flush_IF_ID, flush_ID_EX, flush_EX_MEM  output  1 each  load a bubble (meaningful only with the matching load_*).
- kill_pending  output  1  high in the KILL state.
- stall_cycles  output  CNT_W  count of cycles with load_pc=0.
- redirect_count  output  CNT_W  count of accepted redirects.

Behaviour:
- Combinational terms:
  - d_busy = (dmem_read | dmem_write) & ~dmem_resp
  - i_busy = imem_read & ~imem_resp
- Outputs are combinational from state and inputs. State, pc_target and counters are registered.
- Reset (asynchronous, reset=0):
  - state=RUN, pc_target=0, counters=0.
  - While reset is asserted, all load_*, flush_*, pc_sel and kill_pending are 0.
  - Reset asserted mid-operation abandons any pending redirect.
- FSM states: RUN, KILL, REDIR.
- RUN, evaluated in priority order:
  1. d_busy: all load_*=0, flush_*=0 (full freeze). A redirect is held because MEM is frozen.
  2. MEM_pc_mux_sel:
     - load_IF_ID=load_ID_EX=load_EX_MEM=load_MEM_WB=1; flush_IF_ID=flush_ID_EX=flush_EX_MEM=1.
     - redirect_count+1.
     - If ~i_busy: load_pc=1, pc_sel=1, pc_target driven from MEM_jmp_pc in the same cycle; stay RUN.
     - If i_busy: load_pc=0; latch pc_target<=MEM_jmp_pc; go to KILL.
  3. i_busy: load_pc=0, load_IF_ID=0; load_ID_EX=1 with flush_ID_EX=1 (bubble); load_EX_MEM=load_MEM_WB=1.
  4. load_use_hazard: same enables as rule 3.
  5. Otherwise: all load_*=1, flush_*=0, pc_sel=0.
- KILL (wrong-path fetch in flight):
  - load_pc=0, load_IF_ID=0, kill_pending=1.
  - ID_EX takes a bubble. EX_MEM and MEM_WB load unless d_busy, in which case everything downstream freezes.
  - On imem_resp=1: the instruction is discarded (never loaded into IF_ID); go to REDIR regardless of d_busy.
  - MEM_pc_mux_sel in KILL cannot occur (younger instructions are flushed). If it does, pc_target is overwritten.
- REDIR (one cycle):
  - load_pc=1, pc_sel=1 (pc_target held), load_IF_ID=0.
  - Remaining stages follow RUN rules 1/5.
  - Next state RUN.
- Counters:
  - stall_cycles +1 on every non-reset cycle with load_pc=0.
  - redirect_count +1 per accepted redirect (RUN rule 2).
  - Both saturate at 2^CNT_W-1 with no wrap.
- pc_target holds its value except on a redirect latch. Outside RUN rule 2, REDIR and KILL it is don't-care.
- Fetch and data stalls in the same cycle: the D stall dominates, and the IF stall continues to be honoured once the D stall clears.

Test Plan:
- Reset low for 2 cycles mid-run with state=KILL -> outputs 0, kill_pending=0, counters 0; after release, a free-running pipe gives all load_*=1 and stall_cycles stays 0.
- dmem_read=1 with dmem_resp after 3 cycles -> all load_*=0 for 3 cycles, all 1 on the resp cycle; stall_cycles=3.
- load_use_hazard=1 for 1 cycle -> load_pc=0, load_IF_ID=0, load_ID_EX=1 with flush_ID_EX=1, load_EX_MEM=1; stall_cycles=1.
- MEM_pc_mux_sel=1, MEM_jmp_pc=0x0000_0080, imem idle -> same cycle load_pc=1, pc_sel=1, pc_target=0x80, three flushes; redirect_count=1.
- Redirect to 0x0000_0100 while imem_read=1 with resp 4 cycles later -> KILL for 4 cycles (kill_pending=1); resp discarded with IF_ID unloaded; next cycle REDIR gives load_pc=1, pc_sel=1, pc_target=0x100, then RUN.
- CNT_W=4 with 20 consecutive stall cycles -> stall_cycles saturates at 15.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Central stall/flush sequencer for the 5-stage pipeline. It turns I-/D-memory
// handshakes, load-use hazards and MEM-stage branch redirects into load and
// flush enables for the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB pipe
// registers. If a redirect arrives while a wrong-path fetch is still in
// flight, the target is parked in pc_target. The FSM waits in KILL for that
// fetch to return, throws the returned instruction away, and then applies the
// target in a one-cycle REDIR state.
//
// Handshake semantics: a memory access is outstanding ("busy") while its
// request is high and its one-cycle response pulse is low. The cycle in which
// the response pulse is high counts as complete, so the stage may advance in
// that same cycle.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset (0 = reset)
//   imem_read        IF fetch request active
//   imem_resp        I-memory response pulse
//   dmem_read        MEM-stage load request
//   dmem_write       MEM-stage store request
//   dmem_resp        D-memory response pulse
//   load_use_hazard  ID instruction depends on a load in EX
//   MEM_pc_mux_sel   taken branch/jump resolved in MEM
//   MEM_jmp_pc       redirect target from MEM
//   load_pc          PC register enable
//   pc_sel           1 = PC takes pc_target, 0 = sequential PC
//   pc_target        redirect target
//   load_*           pipe register enables
//   flush_*          load a bubble (only meaningful with the matching load_*)
//   kill_pending     high while in KILL
//   stall_cycles     saturating count of cycles with load_pc = 0
//   redirect_count   saturating count of accepted redirects
//   state_dbg        current FSM state, for observation only
// -----------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_read,
  input  logic              imem_resp,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic              dmem_resp,
  input  logic              load_use_hazard,
  input  logic              MEM_pc_mux_sel,
  input  logic [31:0]       MEM_jmp_pc,
  output logic              load_pc,
  output logic              pc_sel,
  output logic [31:0]       pc_target,
  output logic              load_IF_ID,
  output logic              load_ID_EX,
  output logic              load_EX_MEM,
  output logic              load_MEM_WB,
  output logic              flush_IF_ID,
  output logic              flush_ID_EX,
  output logic              flush_EX_MEM,
  output logic              kill_pending,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  redirect_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_KILL  = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t      state, next_state;
  logic [31:0] target_q;
  logic        d_busy, i_busy;
  logic        latch_target;   // capture MEM_jmp_pc into target_q
  logic        fwd_target;     // present MEM_jmp_pc on pc_target this cycle
  logic        redirect_acc;   // a redirect was accepted this cycle

  assign d_busy = (dmem_read | dmem_write) & ~dmem_resp;
  assign i_busy = imem_read & ~imem_resp;

  // A redirect taken with the fetch side idle is applied in the same cycle,
  // so the target bypasses the register.
  assign pc_target = fwd_target ? MEM_jmp_pc : target_q;
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // State, target and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_RUN;
      target_q       <= 32'h0;
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      state <= next_state;
      if (latch_target) begin
        target_q <= MEM_jmp_pc;
      end
      if (!load_pc && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + CNT_ONE;
      end
      if (redirect_acc && (redirect_count != CNT_MAX)) begin
        redirect_count <= redirect_count + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and enables
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state   = state;
    load_pc      = 1'b0;
    pc_sel       = 1'b0;
    load_IF_ID   = 1'b0;
    load_ID_EX   = 1'b0;
    load_EX_MEM  = 1'b0;
    load_MEM_WB  = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    flush_EX_MEM = 1'b0;
    kill_pending = 1'b0;
    latch_target = 1'b0;
    fwd_target   = 1'b0;
    redirect_acc = 1'b0;

    if (!reset) begin
      // Hold every enable low while reset is asserted. The registers are
      // already cleared, so the next state stays RUN.
      next_state = ST_RUN;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (d_busy) begin
            // Full freeze. A redirect resolved in MEM is held because MEM
            // itself does not advance, and it is accepted once the access
            // completes.
          end else if (MEM_pc_mux_sel) begin
            load_IF_ID   = 1'b1;
            load_ID_EX   = 1'b1;
            load_EX_MEM  = 1'b1;
            load_MEM_WB  = 1'b1;
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
            redirect_acc = 1'b1;
            if (!i_busy) begin
              load_pc    = 1'b1;
              pc_sel     = 1'b1;
              fwd_target = 1'b1;
            end else begin
              // A wrong-path fetch is still outstanding. Park the target
              // until that fetch drains.
              latch_target = 1'b1;
              next_state   = ST_KILL;
            end
          end else if (i_busy || load_use_hazard) begin
            // Hold PC and IF_ID and insert a bubble into ID_EX. Older
            // instructions keep moving.
            load_ID_EX  = 1'b1;
            flush_ID_EX = 1'b1;
            load_EX_MEM = 1'b1;
            load_MEM_WB = 1'b1;
          end else begin
            load_pc     = 1'b1;
            load_IF_ID  = 1'b1;
            load_ID_EX  = 1'b1;
            load_EX_MEM = 1'b1;
            load_MEM_WB = 1'b1;
          end
        end

        ST_KILL: begin
          kill_pending = 1'b1;
          if (!d_busy) begin
            load_ID_EX  = 1'b1;
            flush_ID_EX = 1'b1;
            load_EX_MEM = 1'b1;
            load_MEM_WB = 1'b1;
          end
          // Younger instructions were flushed, so this should not happen. If
          // it does, the newer target wins.
          if (MEM_pc_mux_sel) begin
            latch_target = 1'b1;
          end
          // IF_ID stays closed, which discards the returning wrong-path word.
          if (imem_resp) begin
            next_state = ST_REDIR;
          end
        end

        ST_REDIR: begin
          load_pc = 1'b1;
          pc_sel  = 1'b1;
          if (!d_busy) begin
            load_ID_EX  = 1'b1;
            load_EX_MEM = 1'b1;
            load_MEM_WB = 1'b1;
          end
          next_state = ST_RUN;
        end

        default: begin
          next_state = ST_RUN;
        end
      endcase
    end
  end

endmodule
